uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_tx_scheduler_rr_arbiter.sv | 27 ++
 rtl/uart_tx_scheduler.sv | 97 +++++++++
 tb/tb_uart_tx_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and defaults for the UART byte scheduler
package uart_pkg;
   localparam int TIMEOUT_CYCLES_DEFAULT = 1_250_000;
   typedef enum logic [1:0] {ARB = 2'b01, LOCKED = 2'b10} sched_state_e;
endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick starting after last_grant
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last_grant,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      idx
);
   // scan requesters in order last_grant+1, +2, ... and take the first valid one
   always_comb begin
      int j;
      logic found;
      gnt = '0;
      idx = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = (int'(last_grant) + k) % NUM_REQ;
         if (!found && req[j]) begin
            found = 1'b1;
            gnt[j] = 1'b1;
            idx = IW'(j);
         end
      end
   end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: packet-locked round-robin byte scheduler feeding one UART transmitter
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   localparam int IW = $clog2(NUM_REQ),
   localparam int CW = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [IW-1:0]        grant_id,
   output logic                 busy,
   output logic                 timeout_pulse
);
   sched_state_e state;
   logic [IW-1:0] owner, last_grant, arb_idx, sel;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [CW-1:0] cnt;
   logic hold, can_take, own_valid, accept, sel_last;
   logic [7:0] sel_byte;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req(req_valid),
      .last_grant(last_grant),
      .gnt(arb_gnt),
      .idx(arb_idx)
   );

   assign can_take = !reset && !tx_valid && !hold;
   assign own_valid = req_valid[owner];
   assign req_ready = !can_take ? '0 : state == ARB ? arb_gnt : own_valid ? NUM_REQ'(1) << owner : '0;
   assign accept = |req_ready;
   assign sel = state == ARB ? arb_idx : owner;
   assign busy = state == LOCKED || tx_valid;

   // mux the selected requester's byte and last flag
   always_comb begin
      sel_byte = 8'h00;
      sel_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         if (sel == IW'(i)) begin
            sel_byte = req_data[8*i +: 8];
            sel_last = req_last[i];
         end
   end

   // output buffer, packet lock and idle-timeout release
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ARB;
         owner <= '0;
         last_grant <= IW'(NUM_REQ - 1);
         tx_valid <= 1'b0;
         tx_data <= 8'h00;
         grant_id <= '0;
         cnt <= '0;
         timeout_pulse <= 1'b0;
         hold <= 1'b0;
      end else begin
         hold <= tx_valid && tx_ready;
         timeout_pulse <= 1'b0;
         if (accept) begin
            tx_data <= sel_byte;
            tx_valid <= 1'b1;
            grant_id <= sel;
            cnt <= '0;
            if (sel_last) begin
               state <= ARB;
               last_grant <= sel;
            end else begin
               state <= LOCKED;
               owner <= sel;
            end
         end else begin
            if (tx_valid && tx_ready)
               tx_valid <= 1'b0;
            if (state == LOCKED && !tx_valid && !own_valid) begin
               if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  state <= ARB;
                  last_grant <= owner;
                  timeout_pulse <= 1'b1;
                  cnt <= '0;
               end else
                  cnt <= cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: table, directed and randomized checks against a behavioural model
module tb_uart_tx_scheduler;
   localparam int N = 4;
   localparam int T = 16;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
   logic [7:0] tx_data;
   logic tx_valid, busy, timeout_pulse;
   logic tx_ready = 1'b1;
   logic [1:0] grant_id;
   int checks = 0, failures = 0, cyc = 0;
   bit m_known = 0, m_locked, m_txv, m_hold, m_pulse;
   int m_owner, m_last, m_gid, m_cnt;
   logic [7:0] m_txd;
   logic [7:0] sent[$];

   typedef struct {
      logic [N-1:0] rdy;
      logic txv;
      logic [7:0] txd;
      logic [1:0] gid;
   } vec_t;
   vec_t tbl[12];

   always #5 clk = ~clk;

   uart_tx_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
      .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .grant_id(grant_id),
      .busy(busy), .timeout_pulse(timeout_pulse)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // requester with the smallest rotational distance after the last grant
   function automatic int rr_pick(input logic [N-1:0] v);
      int best = -1;
      int bd = N;
      for (int i = 0; i < N; i++)
         if (v[i] && (i - m_last - 1 + 2*N) % N < bd) begin
            bd = (i - m_last - 1 + 2*N) % N;
            best = i;
         end
      return best;
   endfunction

   task automatic cycle(input bit rst, input logic [8*N-1:0] d, input logic [N-1:0] v,
                        input logic [N-1:0] l, input bit tr);
      logic [N-1:0] er;
      int pick;
      bit otv;
      @(negedge clk);
      reset = rst; req_data = d; req_valid = v; req_last = l; tx_ready = tr;
      #1;
      er = '0;
      pick = -1;
      if (!rst && !m_txv && !m_hold) begin
         pick = m_locked ? (v[m_owner] ? m_owner : -1) : rr_pick(v);
         if (pick >= 0) er[pick] = 1'b1;
      end
      if (m_known) begin
         check("req_ready", 32'(req_ready), 32'(er));
         check("tx_valid", 32'(tx_valid), 32'(m_txv));
         check("tx_data", 32'(tx_data), 32'(m_txd));
         check("grant_id", 32'(grant_id), 32'(m_gid));
         check("busy", 32'(busy), 32'(m_locked || m_txv));
         check("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
      end
      if (!rst && tx_valid && tr) sent.push_back(tx_data);
      otv = m_txv;
      if (rst) begin
         m_known = 1; m_locked = 0; m_owner = 0; m_last = N-1; m_txv = 0;
         m_txd = 8'h00; m_gid = 0; m_cnt = 0; m_pulse = 0; m_hold = 0;
      end else begin
         m_pulse = 0;
         if (pick >= 0) begin
            m_txd = d[pick*8 +: 8];
            m_txv = 1;
            m_gid = pick;
            m_cnt = 0;
            if (l[pick]) begin m_locked = 0; m_last = pick; end
            else begin m_locked = 1; m_owner = pick; end
         end else begin
            if (m_locked && !otv && !v[m_owner]) begin
               if (m_cnt == T-1) begin m_locked = 0; m_last = m_owner; m_pulse = 1; m_cnt = 0; end
               else m_cnt++;
            end
            if (otv && tr) m_txv = 0;
         end
         m_hold = otv && tr;
      end
      cyc++;
   endtask

   task automatic do_reset();
      cycle(1, '0, '0, '0, 1);
      cycle(1, '0, '0, '0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc, pulses, good, viol, idx;
      logic [7:0] pkt[3];
      logic [7:0] q;
      logic [N-1:0] v;
      // round robin between requesters 0 and 2, single-byte packets
      tbl[0]  = '{4'b0001, 1'b0, 8'h00, 2'd0};
      tbl[1]  = '{4'b0000, 1'b1, 8'h10, 2'd0};
      tbl[2]  = '{4'b0000, 1'b0, 8'h10, 2'd0};
      tbl[3]  = '{4'b0100, 1'b0, 8'h10, 2'd0};
      tbl[4]  = '{4'b0000, 1'b1, 8'h30, 2'd2};
      tbl[5]  = '{4'b0000, 1'b0, 8'h30, 2'd2};
      tbl[6]  = '{4'b0001, 1'b0, 8'h30, 2'd2};
      tbl[7]  = '{4'b0000, 1'b1, 8'h10, 2'd0};
      tbl[8]  = '{4'b0000, 1'b0, 8'h10, 2'd0};
      tbl[9]  = '{4'b0100, 1'b0, 8'h10, 2'd0};
      tbl[10] = '{4'b0000, 1'b1, 8'h30, 2'd2};
      tbl[11] = '{4'b0000, 1'b0, 8'h30, 2'd2};
      do_reset();
      for (int i = 0; i < 12; i++) begin
         cycle(0, 32'h4030_2010, 4'b0101, 4'b1111, 1);
         check("tbl_ready", 32'(req_ready), 32'(tbl[i].rdy));
         check("tbl_tx_valid", 32'(tx_valid), 32'(tbl[i].txv));
         check("tbl_tx_data", 32'(tx_data), 32'(tbl[i].txd));
         check("tbl_grant_id", 32'(grant_id), 32'(tbl[i].gid));
      end

      // three-byte packet from requester 1 while requester 3 waits
      do_reset();
      sent.delete();
      pkt[0] = 8'h41; pkt[1] = 8'h42; pkt[2] = 8'h43;
      idx = 0; viol = 0;
      for (int i = 0; i < 40 && sent.size() < 4; i++) begin
         q = idx < 3 ? pkt[idx] : 8'h00;
         cycle(0, {8'hD3, 8'h00, q, 8'h00}, {1'b1, 1'b0, idx < 3, 1'b0}, {1'b1, 1'b0, idx == 2, 1'b0}, 1);
         if (idx < 3 && req_ready[3]) viol++;
         if (req_ready[1]) idx++;
      end
      check("pkt_len", 32'(sent.size()), 32'd4);
      check("pkt_req3_blocked", 32'(viol), 32'd0);
      if (sent.size() >= 4) begin
         check("pkt_b0", 32'(sent[0]), 32'h41);
         check("pkt_b1", 32'(sent[1]), 32'h42);
         check("pkt_b2", 32'(sent[2]), 32'h43);
         check("pkt_b3", 32'(sent[3]), 32'hD3);
      end

      // transmitter stalled for 50 cycles with 0x5A buffered
      do_reset();
      cycle(0, 32'h0000_005A, 4'b0001, 4'b0001, 1);
      good = 0;
      for (int i = 0; i < 50; i++) begin
         cycle(0, 32'h0000_005A, 4'b0001, 4'b0001, 0);
         if (tx_valid && tx_data == 8'h5A && req_ready == '0) good++;
      end
      check("stall_stable", 32'(good), 32'd50);
      cycle(0, 32'h0000_005A, 4'b0001, 4'b0001, 1);
      cycle(0, 32'h0000_005A, 4'b0001, 4'b0001, 1);
      check("hold_tx_valid", 32'(tx_valid), 32'd0);
      check("hold_tx_data", 32'(tx_data), 32'h5A);
      check("hold_ready", 32'(req_ready), 32'd0);

      // requester 2 goes silent mid-packet; lock released after 16 idle cycles
      do_reset();
      acc = cyc;
      cycle(0, 32'h0077_0000, 4'b0100, 4'b0000, 1);
      pulses = 0; good = -1;
      for (int i = 0; i < 25; i++) begin
         cycle(0, 32'hE300_0000, 4'b1000, 4'b1000, 1);
         if (timeout_pulse) begin
            pulses++;
            good = cyc - 1 - acc;
            check("timeout_grant3", 32'(req_ready), 32'b1000);
         end
      end
      check("timeout_pulses", 32'(pulses), 32'd1);
      check("timeout_delay", 32'(good), 32'd18);
      check("timeout_next_gid", 32'(grant_id), 32'd3);

      // owner returns on the expiry cycle: acceptance wins
      do_reset();
      cycle(0, 32'h0066_0000, 4'b0100, 4'b0000, 1);
      for (int i = 0; i < 16; i++) cycle(0, '0, '0, '0, 1);
      cycle(0, 32'h0067_0000, 4'b0100, 4'b0000, 1);
      check("expiry_accept", 32'(req_ready), 32'b0100);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(0, '0, '0, '0, 1);
         if (timeout_pulse) pulses++;
      end
      check("expiry_no_pulse", 32'(pulses), 32'd0);
      check("expiry_locked", 32'(busy), 32'd1);

      // reset while a byte sits in the buffer
      do_reset();
      cycle(0, 32'h0000_9900, 4'b0010, 4'b0000, 0);
      cycle(0, 32'h0000_9900, 4'b0010, 4'b0000, 0);
      check("mid_tx_valid", 32'(tx_valid), 32'd1);
      cycle(1, 32'h0000_9900, 4'b0010, 4'b0000, 0);
      check("rst_ready", 32'(req_ready), 32'd0);
      cycle(0, 32'h4444_4444, 4'b1111, 4'b1111, 1);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_prio0", 32'(req_ready), 32'b0001);

      // randomized traffic with quiet stretches and occasional resets
      for (int i = 0; i < 1500; i++) begin
         v = (i % 120 >= 95 || $urandom % 3 == 0) ? '0 : N'($urandom);
         cycle($urandom % 300 == 0, $urandom, v, N'($urandom), $urandom % 4 != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
